// File: rtl/io_port_pkg.sv
// Shared definitions for the memory-mapped I/O port responder:
// register indices, STATUS bit positions and the register index type.
package io_port_pkg;

  typedef logic [1:0] regIdx_t;

  localparam regIdx_t OFS_PORT_OUT = 2'd0;
  localparam regIdx_t OFS_PORT_IN  = 2'd1;
  localparam regIdx_t OFS_STATUS   = 2'd2;
  localparam regIdx_t OFS_TX_DATA  = 2'd3;

  localparam int ST_IN_CHG = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_IRQ_EN = 4;
  localparam int ST_BITS   = 5;

endpackage

// File: rtl/io_port_fifo.sv
// Synchronous TX FIFO with push, pop, full, empty and count.
// DEPTH is a power of two so the pointers wrap naturally.
module io_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign doPop  = pop && !empty;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Data-bus I/O responder: output port, synchronized input port, STATUS
// and a TX FIFO stream. Optional irq output under IO_PORT_IRQ_EN.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Hit,
  input  logic [7:0]            PortIn,
  output logic [31:0]           PortOut,
  output logic [DATA_WIDTH-1:0] stream_data,
  output logic                  stream_valid,
  input  logic                  stream_ready
`ifdef IO_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  regIdx_t            idx;
  logic               wrEn;
  logic               selOut;
  logic               selIn;
  logic               selStat;
  logic               selTx;
  logic               txPush;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [7:0]         s1;
  logic [7:0]         s2;
  logic [7:0]         prev;
  logic               inChg;
  logic               ovf;
  logic               irqEn;
  logic [ST_BITS-1:0] status;
  logic               unusedBits;

  assign Hit     = Address[31:4] == BASE_ADDR[31:4];
  assign idx     = Address[3:2];
  assign wrEn    = Hit && MemWrite;
  assign selOut  = idx == OFS_PORT_OUT;
  assign selIn   = idx == OFS_PORT_IN;
  assign selStat = idx == OFS_STATUS;
  assign selTx   = idx == OFS_TX_DATA;
  assign txPush  = wrEn && selTx;
  assign pop     = stream_valid && stream_ready;
  assign stream_valid = !empty;
  assign unusedBits   = &{1'b0, Address[1:0]};

  io_port_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (txPush),
    .pop   (pop),
    .din   (WriteData),
    .dout  (stream_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      PortOut <= '0;
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      inChg   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= s2;
      if (wrEn && selOut) begin
        PortOut <= 32'(WriteData);
      end
      // Sticky flags: a new event beats a same-edge W1C.
      if (s2 != prev) begin
        inChg <= 1'b1;
      end else if (wrEn && selStat && WriteData[ST_IN_CHG]) begin
        inChg <= 1'b0;
      end
      if (txPush && full && !pop) begin
        ovf <= 1'b1;
      end else if (wrEn && selStat && WriteData[ST_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef IO_PORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      irqEn <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wrEn && selStat) begin
        irqEn <= WriteData[ST_IRQ_EN];
      end
      irq <= irqEn & (inChg | ovf);
    end
  end
`else
  assign irqEn = 1'b0;
`endif

  always_comb begin
    status            = '0;
    status[ST_IN_CHG] = inChg;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_OVF]    = ovf;
    status[ST_IRQ_EN] = irqEn;
  end

  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      unique case (1'b1)
        selOut:  ReadData = DATA_WIDTH'(PortOut);
        selIn:   ReadData = DATA_WIDTH'(s2);
        selStat: ReadData = DATA_WIDTH'(status);
        selTx:   ReadData = DATA_WIDTH'(count);
        default: ReadData = '0;
      endcase
    end
  end

endmodule
